// File: rtl/register_file_if.sv
// Register-file access bundle: two read ports and one write port, named as in the LEGv8 datapath.
// The master drives indices and write-back; the slave returns the read data.
interface register_file_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] Read_register1;
    logic [ADDR_WIDTH-1:0] Read_register2;
    logic [ADDR_WIDTH-1:0] Write_register;
    logic [DATA_WIDTH-1:0] Write_data;
    logic                  RegWrite;
    logic [DATA_WIDTH-1:0] Read_data1;
    logic [DATA_WIDTH-1:0] Read_data2;

    modport master (
        output Read_register1, Read_register2, Write_register, Write_data, RegWrite,
        input  Read_data1, Read_data2
    );

    modport slave (
        input  Read_register1, Read_register2, Write_register, Write_data, RegWrite,
        output Read_data1, Read_data2
    );
endinterface

// File: rtl/register_file.sv
// LEGv8 register file: 31 x 64-bit storage plus XZR, 2 comb read ports, 1 write port; REGFILE_BYPASS_EN adds write-through.
// Reads are 0-latency, writes commit on the rising edge; no backpressure, always accepts.
module register_file #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    register_file_if.slave     bus
);
    localparam logic [ADDR_WIDTH-1:0] XZR = '1;

    logic [DATA_WIDTH-1:0] regs [0:30];
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    // Unknown RegWrite/Write_register makes the if-condition false, so the file is left untouched.
    assign wr_en = rst_n && bus.RegWrite && (bus.Write_register != XZR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 31; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.Write_register] <= bus.Write_data;
        end
    end

    always_comb begin
        rd1 = (bus.Read_register1 == XZR) ? '0 : regs[bus.Read_register1];
        rd2 = (bus.Read_register2 == XZR) ? '0 : regs[bus.Read_register2];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (bus.Read_register1 == bus.Write_register)) begin
            rd1 = bus.Write_data;
        end
        if (wr_en && (bus.Read_register2 == bus.Write_register)) begin
            rd2 = bus.Write_data;
        end
`endif
    end

    assign bus.Read_data1 = rd1;
    assign bus.Read_data2 = rd2;
endmodule
